// File: rtl/cbfp_denorm.sv
// rtl/cbfp_denorm.sv - CBFP denormaliser: restores 16-lane normalised FFT blocks to full scale
//
// Purpose
//   Inverse of the CBFP normaliser at the FFT output. Per-block shift amounts
//   arrive ahead of the data and wait in an exponent FIFO. Each incoming
//   16-lane block pops one entry. Every lane is sign-extended and scaled up by
//   IN_W-NORM_W bits, then arithmetically shifted right by the block exponent.
//   Real lanes use exp_re and imaginary lanes use exp_im. The data path is a
//   two-stage pipeline that accepts one block per cycle and has no backpressure.
//
// Optional build macro
//   CBFP_DENORM_ROUND_EN - when defined, the right shift rounds half-up and the
//   result saturates to signed IN_W. Latency is 2 cycles in both builds.
//
// Port summary
//   i_clk, i_rst     clock (rising edge) and asynchronous active-high reset
//   i_exp_valid      push {i_exp_re, i_exp_im} into the exponent FIFO
//   i_exp_re/_im     block shift amounts (0..2^SHIFT_W-1)
//   o_exp_full       FIFO holds DEPTH entries
//   o_exp_count      FIFO occupancy
//   i_din_valid      16-lane block present this cycle
//   i_din_real/_imag packed signed NORM_W lanes; lane i at [i*NORM_W +: NORM_W]
//   i_err_clr        clears the sticky error flags
//   o_valid_out      restored block valid (2 cycles after i_din_valid)
//   o_dout_real/_imag packed signed IN_W lanes; they hold their value while idle
//   o_ovf_err        sticky: exponent push dropped because the FIFO was full
//   o_udf_err        sticky: block arrived with no exponent available

module cbfp_denorm #(
  parameter int IN_W    = 23,
  parameter int NORM_W  = 13,
  parameter int SHIFT_W = 5,
  parameter int DEPTH   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_exp_valid,
  input  logic [SHIFT_W-1:0]         i_exp_re,
  input  logic [SHIFT_W-1:0]         i_exp_im,
  output logic                       o_exp_full,
  output logic [$clog2(DEPTH):0]     o_exp_count,
  input  logic                       i_din_valid,
  input  logic [16*NORM_W-1:0]       i_din_real,
  input  logic [16*NORM_W-1:0]       i_din_imag,
  input  logic                       i_err_clr,
  output logic                       o_valid_out,
  output logic [16*IN_W-1:0]         o_dout_real,
  output logic [16*IN_W-1:0]         o_dout_imag,
  output logic                       o_ovf_err,
  output logic                       o_udf_err
);

  localparam int LANES = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int LSH   = IN_W - NORM_W;

  // ---------------------------------------------------------------------------
  // Lane arithmetic: scale up by LSH, then shift right by the block exponent.
  // The scaled value always fits in IN_W bits, so the truncating build needs
  // no saturation.
  // ---------------------------------------------------------------------------
  function automatic logic [IN_W-1:0] f_denorm(input logic [NORM_W-1:0] d,
                                               input logic [SHIFT_W-1:0] e);
`ifdef CBFP_DENORM_ROUND_EN
    logic signed [IN_W+1:0] x;
    logic signed [IN_W+1:0] b;
    logic signed [IN_W+1:0] s;
    logic        [IN_W-1:0] r;
    x = {{(IN_W+2-NORM_W){d[NORM_W-1]}}, d};
    x = x <<< LSH;
    if (int'(e) >= IN_W) begin
      // |x| < 2^(IN_W-1) <= 2^(e-1): x plus the half-LSB bias lies in [0, 2^e),
      // so the rounded result is always 0. Handling it here keeps the bias
      // inside the IN_W+2 intermediate.
      r = '0;
    end else begin
      b = '0;
      if (e != '0) begin
        b = {{(IN_W+1){1'b0}}, 1'b1} << (e - SHIFT_W'(1));
      end
      s = (x + b) >>> e;
      // Saturate to signed IN_W if the top three bits disagree.
      if ((s[IN_W+1:IN_W-1] == 3'b000) || (s[IN_W+1:IN_W-1] == 3'b111)) begin
        r = s[IN_W-1:0];
      end else if (s[IN_W+1]) begin
        r = {1'b1, {(IN_W-1){1'b0}}};
      end else begin
        r = {1'b0, {(IN_W-1){1'b1}}};
      end
    end
    return r;
`else
    logic signed [IN_W:0] x;
    logic signed [IN_W:0] y;
    x = {{(IN_W+1-NORM_W){d[NORM_W-1]}}, d};
    x = x <<< LSH;
    // An arithmetic shift of 31 collapses the value to its sign (0 or -1).
    y = x >>> e;
    return y[IN_W-1:0];
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Exponent FIFO
  // ---------------------------------------------------------------------------
  logic [SHIFT_W-1:0] r_fifo_re [DEPTH];
  logic [SHIFT_W-1:0] r_fifo_im [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_ovf_err;
  logic               r_udf_err;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_bypass;
  logic               w_push;
  logic               w_ovf_set;
  logic               w_udf_set;
  logic [SHIFT_W-1:0] w_sel_re;
  logic [SHIFT_W-1:0] w_sel_im;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = i_din_valid && !w_empty;
  // An exponent that arrives with a block while the FIFO is empty is consumed
  // directly and never stored.
  assign w_bypass  = i_din_valid && w_empty && i_exp_valid;
  // A full FIFO still accepts a push in a cycle that also pops.
  assign w_push    = i_exp_valid && !w_bypass && (!w_full || w_pop);
  assign w_ovf_set = i_exp_valid && w_full && !w_pop;
  assign w_udf_set = i_din_valid && w_empty && !i_exp_valid;

  always_comb begin
    w_sel_re = '0;
    w_sel_im = '0;
    if (!w_empty) begin
      w_sel_re = r_fifo_re[r_rd_ptr];
      w_sel_im = r_fifo_im[r_rd_ptr];
    end else if (i_exp_valid) begin
      w_sel_re = i_exp_re;
      w_sel_im = i_exp_im;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_re[r_wr_ptr] <= i_exp_re;
      r_fifo_im[r_wr_ptr] <= i_exp_im;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A new error in the same cycle as a clear keeps the flag set.
      if (w_ovf_set)      r_ovf_err <= 1'b1;
      else if (i_err_clr) r_ovf_err <= 1'b0;
      if (w_udf_set)      r_udf_err <= 1'b1;
      else if (i_err_clr) r_udf_err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture the block and its exponents. Exponents default to 0 on
  // underflow.
  // ---------------------------------------------------------------------------
  logic                 r_s1_valid;
  logic [16*NORM_W-1:0] r_s1_real;
  logic [16*NORM_W-1:0] r_s1_imag;
  logic [SHIFT_W-1:0]   r_s1_exp_re;
  logic [SHIFT_W-1:0]   r_s1_exp_im;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_real   <= '0;
      r_s1_imag   <= '0;
      r_s1_exp_re <= '0;
      r_s1_exp_im <= '0;
    end else begin
      r_s1_valid <= i_din_valid;
      if (i_din_valid) begin
        r_s1_real   <= i_din_real;
        r_s1_imag   <= i_din_imag;
        r_s1_exp_re <= w_sel_re;
        r_s1_exp_im <= w_sel_im;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: per-lane restore. Outputs update only for valid blocks.
  // ---------------------------------------------------------------------------
  logic               r_valid_out;
  logic [16*IN_W-1:0] r_dout_real;
  logic [16*IN_W-1:0] r_dout_imag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid_out <= 1'b0;
      r_dout_real <= '0;
      r_dout_imag <= '0;
    end else begin
      r_valid_out <= r_s1_valid;
      if (r_s1_valid) begin
        for (int i = 0; i < LANES; i++) begin
          r_dout_real[i*IN_W +: IN_W] <= f_denorm(r_s1_real[i*NORM_W +: NORM_W], r_s1_exp_re);
          r_dout_imag[i*IN_W +: IN_W] <= f_denorm(r_s1_imag[i*NORM_W +: NORM_W], r_s1_exp_im);
        end
      end
    end
  end

  assign o_exp_full  = w_full;
  assign o_exp_count = r_count;
  assign o_valid_out = r_valid_out;
  assign o_dout_real = r_dout_real;
  assign o_dout_imag = r_dout_imag;
  assign o_ovf_err   = r_ovf_err;
  assign o_udf_err   = r_udf_err;

endmodule

// File: tb/tb_cbfp_denorm.sv
// tb/tb_cbfp_denorm.sv - self-checking bench for cbfp_denorm with a queue-based reference model

module tb_cbfp_denorm;

  localparam int IN_W    = 23;
  localparam int NORM_W  = 13;
  localparam int SHIFT_W = 5;
  localparam int DEPTH   = 8;
  localparam int DW      = 16 * IN_W;
`ifdef CBFP_DENORM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   exp_valid;
  logic [SHIFT_W-1:0]     exp_re;
  logic [SHIFT_W-1:0]     exp_im;
  logic                   exp_full;
  logic [$clog2(DEPTH):0] exp_count;
  logic                   din_valid;
  logic [16*NORM_W-1:0]   din_real;
  logic [16*NORM_W-1:0]   din_imag;
  logic                   err_clr;
  logic                   valid_out;
  logic [DW-1:0]          dout_real;
  logic [DW-1:0]          dout_imag;
  logic                   ovf_err;
  logic                   udf_err;

  int n_cmp = 0;
  int n_bad = 0;

  cbfp_denorm #(.IN_W(IN_W), .NORM_W(NORM_W), .SHIFT_W(SHIFT_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_exp_valid(exp_valid), .i_exp_re(exp_re), .i_exp_im(exp_im),
    .o_exp_full(exp_full), .o_exp_count(exp_count),
    .i_din_valid(din_valid), .i_din_real(din_real), .i_din_imag(din_imag),
    .i_err_clr(err_clr),
    .o_valid_out(valid_out), .o_dout_real(dout_real), .o_dout_imag(dout_imag),
    .o_ovf_err(ovf_err), .o_udf_err(udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference value of one lane: value * 2^(IN_W-NORM_W), divided by 2^e with
  // floor (or round-half-up), saturated to signed IN_W.
  function automatic longint ref_lane(input longint d, input int e);
    longint x;
    longint y;
    x = d * (longint'(1) << (IN_W - NORM_W));
    if (RND) y = (x + ((e > 0) ? (longint'(1) << (e - 1)) : 0)) >>> e;
    else     y = x >>> e;
    if (y >  (longint'(1) << (IN_W - 1)) - 1) y =  (longint'(1) << (IN_W - 1)) - 1;
    if (y < -(longint'(1) << (IN_W - 1)))     y = -(longint'(1) << (IN_W - 1));
    return y;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic lit(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic longint lane_r(input int i);
    return longint'($signed(dout_real[i*IN_W +: IN_W]));
  endfunction

  function automatic longint lane_i(input int i);
    return longint'($signed(dout_imag[i*IN_W +: IN_W]));
  endfunction

  // ---------------- behavioural model ----------------
  int                   q_re[$];
  int                   q_im[$];
  bit                   m_ovf, m_udf, m_s1_v, m_v2;
  int                   m_s1_er, m_s1_ei;
  logic [16*NORM_W-1:0] m_s1_real, m_s1_imag;
  logic [DW-1:0]        m_dr, m_di;

  always @(posedge clk or posedge rst) begin : model
    int  er, ei;
    bit  ovf_set, udf_set, byp;
    if (rst) begin
      q_re.delete();
      q_im.delete();
      m_ovf = 0; m_udf = 0; m_s1_v = 0; m_v2 = 0;
      m_s1_er = 0; m_s1_ei = 0; m_s1_real = '0; m_s1_imag = '0;
      m_dr = '0; m_di = '0;
    end else begin
      if (m_s1_v) begin
        for (int i = 0; i < 16; i++) begin
          m_dr[i*IN_W +: IN_W] = IN_W'(ref_lane(longint'($signed(m_s1_real[i*NORM_W +: NORM_W])), m_s1_er));
          m_di[i*IN_W +: IN_W] = IN_W'(ref_lane(longint'($signed(m_s1_imag[i*NORM_W +: NORM_W])), m_s1_ei));
        end
      end
      m_v2 = m_s1_v;
      er = 0; ei = 0; ovf_set = 0; udf_set = 0;
      byp = din_valid && (q_re.size() == 0) && exp_valid;
      if (din_valid) begin
        if (q_re.size() > 0) begin
          er = q_re.pop_front();
          ei = q_im.pop_front();
        end else if (exp_valid) begin
          er = int'(exp_re);
          ei = int'(exp_im);
        end else begin
          udf_set = 1;
        end
      end
      if (exp_valid && !byp) begin
        if (q_re.size() < DEPTH) begin
          q_re.push_back(int'(exp_re));
          q_im.push_back(int'(exp_im));
        end else begin
          ovf_set = 1;
        end
      end
      m_ovf = ovf_set ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
      m_udf = udf_set ? 1'b1 : (err_clr ? 1'b0 : m_udf);
      m_s1_v = din_valid;
      if (din_valid) begin
        m_s1_er = er; m_s1_ei = ei;
        m_s1_real = din_real; m_s1_imag = din_imag;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("valid_out", DW'(valid_out), DW'(m_v2));
    chk("exp_count", DW'(exp_count), DW'(q_re.size()));
    chk("exp_full",  DW'(exp_full),  DW'(q_re.size() == DEPTH));
    chk("ovf_err",   DW'(ovf_err),   DW'(m_ovf));
    chk("udf_err",   DW'(udf_err),   DW'(m_udf));
    chk("dout_real", dout_real, m_dr);
    chk("dout_imag", dout_imag, m_di);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exp_valid = 0; din_valid = 0; err_clr = 0;
    exp_re = '0; exp_im = '0; din_real = '0; din_imag = '0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) begin
      din_real[i*NORM_W +: NORM_W] = NORM_W'($urandom_range(0, (1 << NORM_W) - 1));
      din_imag[i*NORM_W +: NORM_W] = NORM_W'($urandom_range(0, (1 << NORM_W) - 1));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    lit("reset_valid", longint'(valid_out), 0);
    lit("reset_count", longint'(exp_count), 0);
    lit("reset_full",  longint'(exp_full), 0);
    lit("reset_dout",  longint'(dout_real != '0 || dout_imag != '0), 0);
    rst = 1'b0;
    step();

    // Model pins
    lit("ref_100_3",   ref_lane(100, 3),   12800);
    lit("ref_m5_0",    ref_lane(-5, 0),    -5120);
    lit("ref_7_0",     ref_lane(7, 0),     7168);
    lit("ref_1_2",     ref_lane(1, 2),     256);
    lit("ref_3_11",    ref_lane(3, 11),    RND ? 2 : 1);
    lit("ref_m1_31",   ref_lane(-1, 31),   RND ? 0 : -1);
    lit("ref_m3_11",   ref_lane(-3, 11),   RND ? -1 : -2);
    lit("ref_max_0",   ref_lane(4095, 0),  4193280);
    lit("ref_min_0",   ref_lane(-4096, 0), -4194304);

    // Queued exponent, then its block
    exp_valid = 1; exp_re = 3; exp_im = 0;
    step();
    exp_valid = 0; din_valid = 1;
    din_real[0 +: NORM_W] = NORM_W'(100);
    din_imag[0 +: NORM_W] = NORM_W'(-5);
    step();
    idle();
    step();
    lit("t1_valid", longint'(valid_out), 1);
    lit("t1_real0", lane_r(0), 12800);
    lit("t1_imag0", lane_i(0), -5120);

    // Bypass with an empty FIFO
    exp_valid = 1; exp_re = 2; exp_im = 2; din_valid = 1;
    for (int i = 0; i < 16; i++) begin
      din_real[i*NORM_W +: NORM_W] = NORM_W'(1);
      din_imag[i*NORM_W +: NORM_W] = NORM_W'(1);
    end
    step();
    idle();
    lit("t2_count", longint'(exp_count), 0);
    step();
    lit("t2_real7",  lane_r(7), 256);
    lit("t2_imag15", lane_i(15), 256);
    lit("t2_udf",    longint'(udf_err), 0);

    // Underflow: shift 0 is used
    din_valid = 1;
    din_real[5*NORM_W +: NORM_W] = NORM_W'(7);
    step();
    idle();
    lit("t4_udf", longint'(udf_err), 1);
    step();
    lit("t4_real5", lane_r(5), 7168);
    err_clr = 1;
    step();
    err_clr = 0;
    lit("t4_udf_clr", longint'(udf_err), 0);

    // Fill, overflow, push+pop while full
    for (int k = 0; k < 9; k++) begin
      exp_valid = 1;
      exp_re = SHIFT_W'($urandom_range(0, 31));
      exp_im = SHIFT_W'($urandom_range(0, 31));
      step();
      if (k == 7) lit("t3_full8", longint'(exp_full), 1);
    end
    lit("t3_count9", longint'(exp_count), 8);
    lit("t3_ovf",    longint'(ovf_err), 1);
    din_valid = 1; rand_data();
    step();
    lit("t3_pushpop_count", longint'(exp_count), 8);
    lit("t3_pushpop_ovf",   longint'(ovf_err), 1);
    idle();
    err_clr = 1;
    step();
    err_clr = 0;
    lit("t3_ovf_clr", longint'(ovf_err), 0);
    for (int k = 0; k < DEPTH; k++) begin
      din_valid = 1; rand_data();
      step();
    end
    idle();
    step(); step();

    // Shift 11 / shift 31 corner cases
    exp_valid = 1; exp_re = 11; exp_im = 31;
    step();
    exp_valid = 0; din_valid = 1;
    din_real[0 +: NORM_W] = NORM_W'(3);
    din_imag[0 +: NORM_W] = NORM_W'(-1);
    step();
    idle();
    step();
    lit("t5_real0", lane_r(0), RND ? 2 : 1);
    lit("t5_imag0", lane_i(0), RND ? 0 : -1);

    // Randomised traffic at three push densities
    for (int ph = 0; ph < 3; ph++) begin
      int p_ev;
      p_ev = (ph == 0) ? 70 : ((ph == 1) ? 45 : 20);
      for (int c = 0; c < 1000; c++) begin
        exp_valid = ($urandom_range(0, 99) < p_ev);
        exp_re    = SHIFT_W'($urandom_range(0, 31));
        exp_im    = SHIFT_W'($urandom_range(0, 31));
        din_valid = ($urandom_range(0, 99) < 50);
        err_clr   = ($urandom_range(0, 99) < 3);
        rand_data();
        step();
      end
    end
    idle();

    // Reset mid-stream
    for (int k = 0; k < DEPTH; k++) begin
      din_valid = 1; rand_data();
      step();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      exp_valid = 1; exp_re = SHIFT_W'(k); exp_im = SHIFT_W'(k + 1);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      exp_valid = 1; din_valid = 1; rand_data();
      step();
    end
    idle();
    rst = 1'b1;
    #1;
    lit("t6_rst_valid", longint'(valid_out), 0);
    lit("t6_rst_count", longint'(exp_count), 0);
    step();
    rst = 1'b0;
    step();
    exp_valid = 1; exp_re = 3; exp_im = 0;
    step();
    exp_valid = 0; din_valid = 1;
    din_real[0 +: NORM_W] = NORM_W'(100);
    din_imag[0 +: NORM_W] = NORM_W'(-5);
    step();
    idle();
    step();
    lit("t6_real0", lane_r(0), 12800);
    lit("t6_imag0", lane_i(0), -5120);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
